// File: rtl/sc_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package sc_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_LOCK_MAX = 8;
  localparam int LOCK_CNT_W   = 8;

endpackage

// File: rtl/sc_arb_rr_pick.sv
// Combinational next-owner selection: round-robin with a bounded lock.
// With SC_ARB_CPU_PRIORITY_EN defined, requester 0 wins every contention and overrides requester 1's lock.
module sc_arb_rr_pick
  import sc_arb_pkg::*;
#(
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic [1:0]            req,
  input  logic [1:0]            lock,
  input  owner_t                owner,
  input  logic                  last,
  input  logic [LOCK_CNT_W-1:0] lock_cnt,
  output owner_t                next_owner,
  output logic                  next_last,
  output logic [LOCK_CNT_W-1:0] next_lock_cnt
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX - 1);

  logic                  owner_req;
  logic                  owner_lock;
  logic [LOCK_CNT_W-1:0] cnt_inc;

  assign cnt_inc = (lock_cnt == '1) ? lock_cnt : lock_cnt + LOCK_CNT_W'(1);

  always_comb begin
    owner_req     = 1'b0;
    owner_lock    = 1'b0;
    next_owner    = OWN_NONE;
    next_lock_cnt = '0;

    case (owner)
      OWN_R0: begin
        owner_req  = req[0];
        owner_lock = lock[0];
      end
      OWN_R1: begin
        owner_req  = req[1];
        owner_lock = lock[1];
      end
      default: ;
    endcase

`ifdef SC_ARB_CPU_PRIORITY_EN
    if (owner == OWN_R1 && req[0]) owner_lock = 1'b0;
`endif

    if (req == 2'b00) begin
      next_owner    = OWN_NONE;
      next_lock_cnt = '0;
    end else if (owner_req && owner_lock && (lock_cnt < LOCK_LIMIT)) begin
      next_owner    = owner;
      next_lock_cnt = cnt_inc;
    end else if (req == 2'b11) begin
      // last is 1 when R1 was served most recently, so the other side wins the tie
`ifdef SC_ARB_CPU_PRIORITY_EN
      next_owner = OWN_R0;
`else
      next_owner = last ? OWN_R0 : OWN_R1;
`endif
      next_lock_cnt = '0;
    end else begin
      next_owner    = req[0] ? OWN_R0 : OWN_R1;
      next_lock_cnt = (next_owner == owner) ? cnt_inc : '0;
    end

    next_last = (next_owner == OWN_NONE) ? last : (next_owner == OWN_R1);
  end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Shares the single-port data memory / MMIO space between the CPU (r0) and a loader/debug port (r1).
// Optional macro SC_ARB_CPU_PRIORITY_EN gives r0 strict priority over r1.
module sc_dmem_arbiter
  import sc_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

  owner_t                owner_q;
  owner_t                next_owner;
  logic                  last_q;
  logic                  next_last;
  logic [LOCK_CNT_W-1:0] lock_cnt_q;
  logic [LOCK_CNT_W-1:0] next_lock_cnt;
  logic [1:0]            rvalid_q;
  logic [DW-1:0]         rdata0_q;
  logic [DW-1:0]         rdata1_q;
  logic                  owner_we;
  logic                  owner_req;

  sc_arb_rr_pick #(
    .LOCK_MAX(LOCK_MAX)
  ) u_pick (
    .req          ({r1_req, r0_req}),
    .lock         ({r1_lock, r0_lock}),
    .owner        (owner_q),
    .last         (last_q),
    .lock_cnt     (lock_cnt_q),
    .next_owner   (next_owner),
    .next_last    (next_last),
    .next_lock_cnt(next_lock_cnt)
  );

  assign r0_gnt = (owner_q == OWN_R0);
  assign r1_gnt = (owner_q == OWN_R1);

  always_comb begin
    m_addr    = '0;
    m_wdata   = '0;
    owner_we  = 1'b0;
    owner_req = 1'b0;
    case (owner_q)
      OWN_R0: begin
        m_addr    = r0_addr;
        m_wdata   = r0_wdata;
        owner_we  = r0_we;
        owner_req = r0_req;
      end
      OWN_R1: begin
        m_addr    = r1_addr;
        m_wdata   = r1_wdata;
        owner_we  = r1_we;
        owner_req = r1_req;
      end
      default: ;
    endcase
  end

  // owner_req is 0 when nobody owns the bus, so this also implies a grant
  assign m_we = owner_we & owner_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OWN_NONE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      owner_q     <= next_owner;
      last_q      <= next_last;
      lock_cnt_q  <= next_lock_cnt;
      rvalid_q[0] <= r0_req & r0_gnt & ~r0_we;
      rvalid_q[1] <= r1_req & r1_gnt & ~r1_we;
      if (rvalid_q[0]) rdata0_q <= m_rdata;
      if (rvalid_q[1]) rdata1_q <= m_rdata;
    end
  end

  // Memory data arrives the cycle after the read; forward it, then hold it
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_rdata  = rvalid_q[0] ? m_rdata : rdata0_q;
  assign r1_rdata  = rvalid_q[1] ? m_rdata : rdata1_q;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed self-checking bench for sc_dmem_arbiter with a synchronous-read memory model.
// Expectations follow SC_ARB_CPU_PRIORITY_EN when it is defined.
module tb_sc_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we;
  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  sc_dmem_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_lock  (r0_lock),
    .r0_gnt   (r0_gnt),
    .r0_rvalid(r0_rvalid),
    .r0_rdata (r0_rdata),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_lock  (r1_lock),
    .r1_gnt   (r1_gnt),
    .r1_rvalid(r1_rvalid),
    .r1_rdata (r1_rdata),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_we     (m_we),
    .m_rdata  (m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memory standing in for sc_datamem
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      m_rdata <= 32'h0;
    end else begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      m_rdata <= mem[m_addr[7:2]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus_idle();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus_idle();
    tick();
    tick();
    check_output("rst_r0_gnt", {31'd0, r0_gnt}, 32'd0);
    check_output("rst_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    check_output("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    check_output("rst_r0_rdata", r0_rdata, 32'd0);
    check_output("rst_m_we", {31'd0, m_we}, 32'd0);
    check_output("rst_m_addr", m_addr, 32'd0);
    reset = 1'b0;

    $display("[TB] single r0 write then read");
    r0_req = 1; r0_we = 1; r0_addr = 32'h20; r0_wdata = 32'hDEADBEEF;
    #1;
    check_output("wr_pre_gnt", {31'd0, r0_gnt}, 32'd0);
    check_output("wr_pre_m_we", {31'd0, m_we}, 32'd0);
    tick();
    check_output("wr_gnt", {31'd0, r0_gnt}, 32'd1);
    check_output("wr_m_we", {31'd0, m_we}, 32'd1);
    check_output("wr_m_addr", m_addr, 32'h20);
    check_output("wr_m_wdata", m_wdata, 32'hDEADBEEF);
    tick();
    r0_we = 0;
    #1;
    check_output("rd_m_we", {31'd0, m_we}, 32'd0);
    check_output("rd_gnt", {31'd0, r0_gnt}, 32'd1);
    check_output("wr_no_rvalid", {31'd0, r0_rvalid}, 32'd0);
    tick();
    r0_req = 0;
    check_output("rd_rvalid", {31'd0, r0_rvalid}, 32'd1);
    check_output("rd_rdata", r0_rdata, 32'hDEADBEEF);
    tick();
    check_output("rd_rvalid_once", {31'd0, r0_rvalid}, 32'd0);
    check_output("rd_rdata_hold", r0_rdata, 32'hDEADBEEF);
    check_output("rd_release_gnt", {31'd0, r0_gnt}, 32'd0);

    $display("[TB] reset in the middle of a read");
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    tick();
    check_output("midrd_gnt", {31'd0, r0_gnt}, 32'd1);
    reset = 1'b1;
    tick();
    check_output("midrd_rvalid", {31'd0, r0_rvalid}, 32'd0);
    check_output("midrd_gnt0", {31'd0, r0_gnt}, 32'd0);
    check_output("midrd_gnt1", {31'd0, r1_gnt}, 32'd0);
    check_output("midrd_m_we", {31'd0, m_we}, 32'd0);
    check_output("midrd_rdata", r0_rdata, 32'd0);

    $display("[TB] continuous contention without lock");
    r0_req = 1; r0_addr = 32'h104;
    r1_req = 1; r1_addr = 32'h208;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic exp_r0;
      tick();
`ifdef SC_ARB_CPU_PRIORITY_EN
      exp_r0 = 1'b1;
`else
      exp_r0 = (i % 2 == 0);
`endif
      check_output($sformatf("cont_r0_gnt_%0d", i), {31'd0, r0_gnt}, {31'd0, exp_r0});
      check_output($sformatf("cont_r1_gnt_%0d", i), {31'd0, r1_gnt}, {31'd0, ~exp_r0});
      check_output($sformatf("cont_m_addr_%0d", i), m_addr, exp_r0 ? 32'h104 : 32'h208);
    end

    $display("[TB] r1 locked burst with r0 waiting");
    reset = 1'b1;
    apply_stimulus_idle();
    tick();
    reset = 1'b0;
    r1_req = 1; r1_lock = 1; r1_addr = 32'h30;
    tick();
    check_output("lock_first_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    r0_req = 1; r0_addr = 32'h34;
`ifdef SC_ARB_CPU_PRIORITY_EN
    tick();
    check_output("prio_r0_gnt_a", {31'd0, r0_gnt}, 32'd1);
    tick();
    check_output("prio_r0_gnt_b", {31'd0, r0_gnt}, 32'd1);
`else
    for (int i = 1; i < 8; i++) begin
      tick();
      check_output($sformatf("lock_r1_gnt_%0d", i), {31'd0, r1_gnt}, 32'd1);
    end
    tick();
    check_output("lock_expire_r0_gnt", {31'd0, r0_gnt}, 32'd1);
    check_output("lock_expire_r1_gnt", {31'd0, r1_gnt}, 32'd0);
    tick();
    check_output("lock_regain_r1_gnt", {31'd0, r1_gnt}, 32'd1);
`endif

    $display("[TB] r1 drops req while granted");
    reset = 1'b1;
    apply_stimulus_idle();
    tick();
    reset = 1'b0;
    r1_req = 1; r1_we = 0; r1_addr = 32'h40;
    tick();
    check_output("drop_r1_gnt", {31'd0, r1_gnt}, 32'd1);
    r1_req = 0; r1_we = 1; r1_addr = 32'h44; r1_wdata = 32'h55;
    #1;
    check_output("drop_m_we", {31'd0, m_we}, 32'd0);
    tick();
    check_output("drop_r1_gnt_none", {31'd0, r1_gnt}, 32'd0);
    check_output("drop_r0_gnt_none", {31'd0, r0_gnt}, 32'd0);
    check_output("drop_no_rvalid", {31'd0, r1_rvalid}, 32'd0);
    r1_req = 1; r1_we = 0; r1_addr = 32'h44;
    tick();
    tick();
    r1_req = 0;
    check_output("drop_rb_rvalid", {31'd0, r1_rvalid}, 32'd1);
    check_output("drop_rb_rdata", r1_rdata, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
